// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 5-stage core (IF, ID, EX, LS, WB).
// Owns the per-stage valid bits and produces the PC / pipeline-register
// write enables plus the stall and flush indications.
//
// Ports:
//   i_clk, i_rst                 clock (rising edge), async active-high reset
//   i_pause                      global freeze: all enables low, state holds
//   i_ifu_valid                  IFU presents a fetched instruction
//   i_id_rs1id/rs2id/rs1en/rs2en source operands of the instruction in ID
//   i_ex_rdid/rdwen/isld/ismc    destination and class of the instruction in EX
//   i_ex_redirect                EX resolved a taken branch/jump
//   o_pc_wen, o_*_wen            PC and pipeline register write enables (comb)
//   o_id/ex/ls/wb_valid          stage holds a real instruction (registered)
//   o_ldstall/o_mcbusy/o_flush   load-use stall / multi-cycle stall / redirect flush
//
// Optional: define PIPE_PERF_CNT_EN to add 32-bit event counters
//   o_perf_ldstall, o_perf_mcstall, o_perf_flush (frozen while paused).
module pipe_ctrl #(
  parameter int unsigned REG_ADDRW = 5,
  parameter int unsigned MC_LAT    = 8,
  localparam int unsigned CNT_W    = $clog2(MC_LAT)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pause,
  input  logic                 i_ifu_valid,
  input  logic [REG_ADDRW-1:0] i_id_rs1id,
  input  logic [REG_ADDRW-1:0] i_id_rs2id,
  input  logic                 i_id_rs1en,
  input  logic                 i_id_rs2en,
  input  logic [REG_ADDRW-1:0] i_ex_rdid,
  input  logic                 i_ex_rdwen,
  input  logic                 i_ex_isld,
  input  logic                 i_ex_ismc,
  input  logic                 i_ex_redirect,
  output logic                 o_pc_wen,
  output logic                 o_if_id_wen,
  output logic                 o_id_ex_wen,
  output logic                 o_ex_ls_wen,
  output logic                 o_ls_wb_wen,
  output logic                 o_id_valid,
  output logic                 o_ex_valid,
  output logic                 o_ls_valid,
  output logic                 o_wb_valid,
  output logic                 o_ldstall,
  output logic                 o_mcbusy,
  output logic                 o_flush
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]          o_perf_ldstall,
  output logic [31:0]          o_perf_mcstall,
  output logic [31:0]          o_perf_flush
`endif
);

  // Entry cycle stalls in IDLE, then MC_LAT-2 RUN cycles down to zero,
  // then the release cycle: MC_LAT cycles of EX occupancy in total.
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MC_LAT - 2);

  typedef enum logic {
    MC_IDLE,
    MC_RUN
  } mc_state_e;

  mc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             id_v_q, ex_v_q, ls_v_q, wb_v_q;
  logic             id_v_d, ex_v_d, ls_v_d, wb_v_d;

  logic mc_start_c, mcstall_c, flush_raw_c, ldstall_raw_c;
  logic rs1_hit_c, rs2_hit_c;

  // Hazard terms, all qualified by the stage valids.
  assign mc_start_c    = (state_q == MC_IDLE) & ex_v_q & i_ex_ismc;
  assign mcstall_c     = mc_start_c | ((state_q == MC_RUN) & (cnt_q != '0));
  assign flush_raw_c   = ex_v_q & i_ex_redirect & ~mcstall_c;
  assign rs1_hit_c     = i_id_rs1en & (i_id_rs1id == i_ex_rdid);
  assign rs2_hit_c     = i_id_rs2en & (i_id_rs2id == i_ex_rdid);
  assign ldstall_raw_c = id_v_q & ex_v_q & i_ex_isld & i_ex_rdwen &
                         (i_ex_rdid != '0) & (rs1_hit_c | rs2_hit_c);

  assign o_id_valid = id_v_q;
  assign o_ex_valid = ex_v_q;
  assign o_ls_valid = ls_v_q;
  assign o_wb_valid = wb_v_q;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= MC_IDLE;
      cnt_q   <= '0;
      id_v_q  <= 1'b0;
      ex_v_q  <= 1'b0;
      ls_v_q  <= 1'b0;
      wb_v_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_v_q  <= id_v_d;
      ex_v_q  <= ex_v_d;
      ls_v_q  <= ls_v_d;
      wb_v_q  <= wb_v_d;
    end
  end

  // Next state, valid propagation and enables; priority pause > mc > flush > ldstall.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    id_v_d      = id_v_q;
    ex_v_d      = ex_v_q;
    ls_v_d      = ls_v_q;
    wb_v_d      = wb_v_q;
    o_pc_wen    = 1'b0;
    o_if_id_wen = 1'b0;
    o_id_ex_wen = 1'b0;
    o_ex_ls_wen = 1'b0;
    o_ls_wb_wen = 1'b0;
    o_ldstall   = 1'b0;
    o_mcbusy    = 1'b0;
    o_flush     = 1'b0;

    if (!i_pause) begin
      case (state_q)
        MC_IDLE: begin
          if (mc_start_c) begin
            state_d = MC_RUN;
            cnt_d   = CNT_START;
          end
        end
        MC_RUN: begin
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
          else             state_d = MC_IDLE;
        end
      endcase

      // Back half of the pipe always drains.
      o_ex_ls_wen = 1'b1;
      o_ls_wb_wen = 1'b1;
      wb_v_d      = ls_v_q;

      if (mcstall_c) begin
        o_mcbusy = 1'b1;
        ls_v_d   = 1'b0;
      end else begin
        ls_v_d      = ex_v_q;
        o_id_ex_wen = 1'b1;
        if (flush_raw_c) begin
          // Squash ID and EX; the ID load-use stall is moot.
          o_pc_wen    = 1'b1;
          o_if_id_wen = 1'b1;
          o_flush     = 1'b1;
          id_v_d      = 1'b0;
          ex_v_d      = 1'b0;
        end else if (ldstall_raw_c) begin
          o_ldstall = 1'b1;
          ex_v_d    = 1'b0;
        end else begin
          o_pc_wen    = 1'b1;
          o_if_id_wen = 1'b1;
          id_v_d      = i_ifu_valid;
          ex_v_d      = id_v_q;
        end
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Event counters; flags are already zero while paused.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_perf_ldstall <= '0;
      o_perf_mcstall <= '0;
      o_perf_flush   <= '0;
    end else begin
      if (o_ldstall) o_perf_ldstall <= o_perf_ldstall + 32'd1;
      if (o_mcbusy)  o_perf_mcstall <= o_perf_mcstall + 32'd1;
      if (o_flush)   o_perf_flush   <= o_perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: a bench-side pipeline of instruction records
// drives the ID/EX inputs; a cycle-level model of the sequencing rules
// predicts enables, flags and valids every cycle.
module tb_pipe_ctrl;
  localparam int unsigned REG_ADDRW = 5;
  localparam int unsigned MC_LAT    = 8;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rs1en;
    logic       rs2en;
    logic       rdwen;
    logic       isld;
    logic       ismc;
    logic       redir;
  } instr_t;

  logic i_clk = 1'b0, i_rst = 1'b1, i_pause = 1'b0, i_ifu_valid = 1'b0;
  logic [REG_ADDRW-1:0] i_id_rs1id = '0, i_id_rs2id = '0, i_ex_rdid = '0;
  logic i_id_rs1en = 1'b0, i_id_rs2en = 1'b0, i_ex_rdwen = 1'b0;
  logic i_ex_isld = 1'b0, i_ex_ismc = 1'b0, i_ex_redirect = 1'b0;
  logic o_pc_wen, o_if_id_wen, o_id_ex_wen, o_ex_ls_wen, o_ls_wb_wen;
  logic o_id_valid, o_ex_valid, o_ls_valid, o_wb_valid;
  logic o_ldstall, o_mcbusy, o_flush;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_ld, perf_mc, perf_fl;
`endif

  always #5 i_clk = ~i_clk;

  pipe_ctrl #(.REG_ADDRW(REG_ADDRW), .MC_LAT(MC_LAT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pause(i_pause), .i_ifu_valid(i_ifu_valid),
    .i_id_rs1id(i_id_rs1id), .i_id_rs2id(i_id_rs2id),
    .i_id_rs1en(i_id_rs1en), .i_id_rs2en(i_id_rs2en),
    .i_ex_rdid(i_ex_rdid), .i_ex_rdwen(i_ex_rdwen), .i_ex_isld(i_ex_isld),
    .i_ex_ismc(i_ex_ismc), .i_ex_redirect(i_ex_redirect),
    .o_pc_wen(o_pc_wen), .o_if_id_wen(o_if_id_wen), .o_id_ex_wen(o_id_ex_wen),
    .o_ex_ls_wen(o_ex_ls_wen), .o_ls_wb_wen(o_ls_wb_wen),
    .o_id_valid(o_id_valid), .o_ex_valid(o_ex_valid),
    .o_ls_valid(o_ls_valid), .o_wb_valid(o_wb_valid),
    .o_ldstall(o_ldstall), .o_mcbusy(o_mcbusy), .o_flush(o_flush)
`ifdef PIPE_PERF_CNT_EN
    , .o_perf_ldstall(perf_ld), .o_perf_mcstall(perf_mc), .o_perf_flush(perf_fl)
`endif
  );

  // Model: instruction records in ID/EX, stage valids, unpaused cycles EX op has spent.
  instr_t m_id, m_ex;
  bit     m_idv, m_exv, m_lsv, m_wbv;
  int     m_age;
  instr_t prog_q[$];
  int     n_cmp = 0, n_bad = 0;
  int     cnt_ld, cnt_mc, cnt_fl, cyc, first_id, first_wb;

  function automatic instr_t rand_instr();
    instr_t t;
    t.rs1   = 5'($urandom_range(0, 3));
    t.rs2   = 5'($urandom_range(0, 3));
    t.rd    = 5'($urandom_range(0, 3));
    t.rs1en = 1'($urandom);
    t.rs2en = 1'($urandom);
    t.rdwen = 1'($urandom);
    t.isld  = ($urandom_range(0, 3) == 0);
    t.ismc  = ($urandom_range(0, 7) == 0);
    t.redir = ($urandom_range(0, 7) == 0);
    return t;
  endfunction

  function automatic instr_t alu(input int rd, input int rs1, input bit e1, input int rs2, input bit e2);
    instr_t t = '0;
    t.rd = 5'(rd); t.rdwen = 1'b1;
    t.rs1 = 5'(rs1); t.rs1en = e1;
    t.rs2 = 5'(rs2); t.rs2en = e2;
    return t;
  endfunction

  task automatic model_reset();
    m_idv = 0; m_exv = 0; m_lsv = 0; m_wbv = 0; m_age = 0;
    m_id = '0; m_ex = '0;
    prog_q.delete();
    cnt_ld = 0; cnt_mc = 0; cnt_fl = 0; cyc = 0; first_id = -1; first_wb = -1;
  endtask

  task automatic apply_reset();
    i_rst = 1'b1; i_pause = 1'b0; i_ifu_valid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive from the model, compare everything, advance the model.
  task automatic step(input bit p, input bit ifu);
    instr_t gid, gex;
    logic [11:0] exp, act;
    bit mc, fl, ld;
    i_pause = p; i_ifu_valid = ifu;
    gid = m_idv ? m_id : rand_instr();
    gex = m_exv ? m_ex : rand_instr();
    i_id_rs1id = gid.rs1; i_id_rs2id = gid.rs2;
    i_id_rs1en = gid.rs1en; i_id_rs2en = gid.rs2en;
    i_ex_rdid = gex.rd; i_ex_rdwen = gex.rdwen; i_ex_isld = gex.isld;
    i_ex_ismc = gex.ismc; i_ex_redirect = gex.redir;
    #1;
    mc = m_exv && m_ex.ismc && (m_age < int'(MC_LAT) - 1);
    fl = m_exv && m_ex.redir && !mc;
    ld = m_idv && m_exv && m_ex.isld && m_ex.rdwen && (m_ex.rd != 0) &&
         ((m_id.rs1en && m_id.rs1 == m_ex.rd) || (m_id.rs2en && m_id.rs2 == m_ex.rd));
    if (p)       exp[11:7] = 5'b00000;
    else if (mc) exp[11:7] = 5'b00011;
    else if (fl) exp[11:7] = 5'b11111;
    else if (ld) exp[11:7] = 5'b00111;
    else         exp[11:7] = 5'b11111;
    exp[6:3] = {m_idv, m_exv, m_lsv, m_wbv};
    exp[2]   = !p && !mc && !fl && ld;
    exp[1]   = !p && mc;
    exp[0]   = !p && fl;
    act = {o_pc_wen, o_if_id_wen, o_id_ex_wen, o_ex_ls_wen, o_ls_wb_wen,
           o_id_valid, o_ex_valid, o_ls_valid, o_wb_valid, o_ldstall, o_mcbusy, o_flush};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL cycle_ctrl t=%0t got %b want %b (pc ifid idex exls lswb | id ex ls wb | ld mc fl)",
               $time, act, exp);
    end
    cnt_ld += int'(o_ldstall); cnt_mc += int'(o_mcbusy); cnt_fl += int'(o_flush);
    if (o_id_valid === 1'b1 && first_id < 0) first_id = cyc;
    if (o_wb_valid === 1'b1 && first_wb < 0) first_wb = cyc;
    if (!p) begin
      if (mc) begin
        m_wbv = m_lsv; m_lsv = 0; m_age++;
      end else begin
        m_wbv = m_lsv; m_lsv = m_exv; m_age = 0;
        if (fl) begin
          m_idv = 0; m_exv = 0;
        end else if (ld) begin
          m_exv = 0;
        end else begin
          m_exv = m_idv; m_ex = m_id; m_idv = ifu;
          if (ifu) m_id = (prog_q.size() > 0) ? prog_q.pop_front() : rand_instr();
        end
      end
    end
    cyc++;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic run(input int n, input bit ifu);
    for (int i = 0; i < n; i++) step(1'b0, ifu);
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_pause = 1'b0;
    @(negedge i_clk); #1;
    n_cmp++;
    if ({o_pc_wen, o_if_id_wen, o_id_ex_wen, o_ex_ls_wen, o_ls_wb_wen, o_id_valid, o_ex_valid,
         o_ls_valid, o_wb_valid, o_ldstall, o_mcbusy, o_flush} !== 12'b111110000000) begin
      n_bad++;
      $display("FAIL reset_state got %b%b%b%b%b %b%b%b%b %b%b%b want 11111 0000 000",
               o_pc_wen, o_if_id_wen, o_id_ex_wen, o_ex_ls_wen, o_ls_wb_wen,
               o_id_valid, o_ex_valid, o_ls_valid, o_wb_valid, o_ldstall, o_mcbusy, o_flush);
    end
    i_pause = 1'b1; #1;
    n_cmp++;
    if ({o_pc_wen, o_if_id_wen, o_id_ex_wen, o_ex_ls_wen, o_ls_wb_wen} !== 5'b00000) begin
      n_bad++;
      $display("FAIL reset_pause_wens got %b%b%b%b%b want 00000",
               o_pc_wen, o_if_id_wen, o_id_ex_wen, o_ex_ls_wen, o_ls_wb_wen);
    end
    i_pause = 1'b0;
    apply_reset();
  endtask

  task automatic test_stream();
    apply_reset();
    for (int i = 1; i <= 4; i++) prog_q.push_back(alu(i, 0, 0, 0, 0));
    run(4, 1'b1);
    run(5, 1'b0);
    n_cmp++;
    if (first_wb - first_id != 3 || (cnt_ld + cnt_mc + cnt_fl) != 0) begin
      n_bad++;
      $display("FAIL stream_latency got id@%0d wb@%0d stalls=%0d want wb 3 after id, 0 stalls",
               first_id, first_wb, cnt_ld + cnt_mc + cnt_fl);
    end
  endtask

  task automatic test_loaduse(input int rd, input int want);
    instr_t t;
    apply_reset();
    t = alu(rd, 1, 1, 2, 0); t.isld = 1'b1;
    prog_q.push_back(t);
    prog_q.push_back(alu(6, 1, 1, rd, 1));
    run(2, 1'b1);
    run(6, 1'b0);
    n_cmp++;
    if (cnt_ld != want) begin
      n_bad++;
      $display("FAIL loaduse_rd%0d got %0d stall cycles want %0d", rd, cnt_ld, want);
    end
  endtask

  task automatic test_div(input int pause_at);
    instr_t t;
    int ex_cycles;
    apply_reset();
    t = alu(7, 1, 1, 2, 1); t.ismc = 1'b1;
    prog_q.push_back(t);
    prog_q.push_back(alu(8, 1, 1, 0, 0));
    prog_q.push_back(alu(9, 7, 1, 0, 0));
    run(2, 1'b1);
    ex_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (i >= pause_at && i < pause_at + 3) step(1'b1, 1'b1);
      else step(1'b0, 1'b1);
      if (cnt_mc < MC_LAT - 1 || o_mcbusy === 1'b1) ex_cycles++;
      if (o_id_ex_wen === 1'b1 && o_pause_free()) break;
    end
    run(6, 1'b0);
    n_cmp++;
    if (cnt_mc != int'(MC_LAT) - 1) begin
      n_bad++;
      $display("FAIL div_busy_cycles pause_at=%0d got %0d want %0d", pause_at, cnt_mc, MC_LAT - 1);
    end
  endtask

  function automatic bit o_pause_free();
    return i_pause == 1'b0;
  endfunction

  task automatic test_flush_ldhazard();
    instr_t t;
    apply_reset();
    t = alu(5, 1, 1, 2, 0); t.isld = 1'b1; t.redir = 1'b1;
    prog_q.push_back(t);
    prog_q.push_back(alu(6, 5, 1, 0, 0));
    run(2, 1'b1);
    run(5, 1'b0);
    n_cmp++;
    if (cnt_fl != 1 || cnt_ld != 0) begin
      n_bad++;
      $display("FAIL flush_masks_ld got flush=%0d ld=%0d want flush=1 ld=0", cnt_fl, cnt_ld);
    end
  endtask

  task automatic test_reset_mid_div();
    instr_t t;
    apply_reset();
    t = alu(7, 1, 1, 2, 1); t.ismc = 1'b1;
    prog_q.push_back(t);
    run(2, 1'b1);
    run(3, 1'b0);
    #2 i_rst = 1'b1;
    #1;
    n_cmp++;
    if ({o_id_valid, o_ex_valid, o_ls_valid, o_wb_valid, o_mcbusy} !== 5'b00000) begin
      n_bad++;
      $display("FAIL async_reset_mid_div got valids=%b%b%b%b mcbusy=%b want 0000 0",
               o_id_valid, o_ex_valid, o_ls_valid, o_wb_valid, o_mcbusy);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
    prog_q.push_back(alu(3, 1, 1, 0, 0));
    run(1, 1'b1);
    run(5, 1'b0);
    n_cmp++;
    if (first_wb - first_id != 3 || cnt_mc != 0) begin
      n_bad++;
      $display("FAIL post_reset_flow got id@%0d wb@%0d mcbusy=%0d want wb 3 after id, 0",
               first_id, first_wb, cnt_mc);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_loaduse(5, 1);
    test_loaduse(0, 0);
    test_div(100);
    test_flush_ldhazard();
    test_div(2);
    test_reset_mid_div();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
